fsm_trace_decoder: RTL and testbench

Observes the 4-bit state stream produced by the microcoded sequencer and recovers the 2-bit input symbols that steered each dispatch. It checks every observed transition against the shared microcode table and flags illegal transitions. It counts completed passes through state 0. Recovered symbols are buffered in a small FIFO with a valid/ready handshake for the bench scoreboard or a downstream checker.

---
 rtl/fsm_ucode_pkg.sv | 29 ++
 rtl/sym_fifo.sv | 56 +++++
 rtl/fsm_trace_decoder.sv | 138 +++++++++++++
 tb/tb_fsm_trace_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_ucode_pkg.sv
// Shared microcode table of the sequencer: branch kind per state and the dispatch ROMs.
// Pure constants and a combinational lookup; no timing or flow control involved.
package fsm_ucode_pkg;

  typedef enum logic [2:0] {
    BR_INC   = 3'b000,
    BR_DISP1 = 3'b001,
    BR_GOTO7 = 3'b010,
    BR_DISP2 = 3'b011,
    BR_GOTO0 = 3'b100
  } branch_e;

  // Entry i is the dispatch target for input symbol i.
  localparam logic [3:0][3:0] DISP1_ROM = {4'd6, 4'd6, 4'd5, 4'd4};
  localparam logic [3:0][3:0] DISP2_ROM = {4'd12, 4'd12, 4'd12, 4'd11};

  function automatic branch_e ucode_branch(input logic [3:0] state);
    branch_e br;
    case (state)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9: br = BR_INC;
      4'd3:                                     br = BR_DISP1;
      4'd4, 4'd5:                               br = BR_GOTO7;
      4'd10:                                    br = BR_DISP2;
      default:                                  br = BR_GOTO0;
    endcase
    return br;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Small FIFO for recovered symbols; registered head, push visible one cycle later (no fall-through).
// Push while full is refused unless a pop happens in the same cycle; pop while empty is ignored.
module sym_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         pop_ok, push_ok;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_dat;
      wr_d                = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/fsm_trace_decoder.sv
// Checks observed sequencer transitions against the microcode table and recovers dispatch symbols.
// Status updates one edge after the sample; symbols queue in a FIFO, dropped (overflow) when full.
module fsm_trace_decoder
  import fsm_ucode_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             state_valid,
  input  logic [3:0]       state_in,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [1:0]       sym_data,
  output logic             sym_ambig,
  output logic             err,
  output logic [3:0]       err_from,
  output logic [3:0]       err_to,
  output logic             overflow,
  output logic [CNT_W-1:0] pass_cnt
);

  logic [3:0]       prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             err_q, err_d;
  logic [3:0]       err_from_q, err_from_d;
  logic [3:0]       err_to_q, err_to_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] pass_q, pass_d;

  logic             legal, is_disp;
  logic [3:0][3:0]  rom;
  logic [1:0]       dsym;
  logic [2:0]       nmatch;
  logic             push, pop, fifo_full, fifo_empty;
  logic [2:0]       fifo_head;

  // Transition legality and dispatch decode for prev_q -> state_in.
  always_comb begin
    legal   = 1'b0;
    is_disp = 1'b0;
    rom     = DISP1_ROM;
    dsym    = 2'd0;
    nmatch  = 3'd0;
    case (ucode_branch(prev_q))
      BR_INC:   legal = (state_in == 4'(prev_q + 4'd1));
      BR_GOTO7: legal = (state_in == 4'd7);
      BR_GOTO0: legal = (state_in == 4'd0);
      BR_DISP1: is_disp = 1'b1;
      BR_DISP2: begin
        is_disp = 1'b1;
        rom     = DISP2_ROM;
      end
      default:  legal = 1'b0;
    endcase
    if (is_disp) begin
      // Descending scan leaves the lowest input that reaches the target.
      for (int i = 3; i >= 0; i--) begin
        if (rom[i] == state_in) begin
          dsym   = 2'(i);
          nmatch = nmatch + 3'd1;
        end
      end
      legal = (nmatch != 3'd0);
    end
  end

  assign pop = sym_valid && sym_ready;

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    err_d       = err_q;
    err_from_d  = err_from_q;
    err_to_d    = err_to_q;
    pass_d      = pass_q;
    push        = 1'b0;
    if (state_valid) begin
      prev_d      = state_in;
      have_prev_d = 1'b1;
      if (have_prev_q) begin
        if (legal) begin
          push = is_disp;
          if (state_in == 4'd0) pass_d = pass_q + CNT_W'(1);
        end else begin
          err_d = 1'b1;
          if (!err_q) begin
            err_from_d = prev_q;
            err_to_d   = state_in;
          end
        end
      end
    end
    overflow_d = overflow_q || (push && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
      err_from_q  <= '0;
      err_to_q    <= '0;
      overflow_q  <= 1'b0;
      pass_q      <= '0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      err_q       <= err_d;
      err_from_q  <= err_from_d;
      err_to_q    <= err_to_d;
      overflow_q  <= overflow_d;
      pass_q      <= pass_d;
    end
  end

  sym_fifo #(.DEPTH(FIFO_DEPTH), .W(3)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({nmatch > 3'd1, dsym}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign sym_valid = !fifo_empty;
  assign sym_data  = fifo_head[1:0];
  assign sym_ambig = fifo_head[2];
  assign err       = err_q;
  assign err_from  = err_from_q;
  assign err_to    = err_to_q;
  assign overflow  = overflow_q;
  assign pass_cnt  = pass_q;

endmodule

// File: tb/tb_fsm_trace_decoder.sv
// Drives directed and random sequencer traces into fsm_trace_decoder and compares every cycle
// against a queue-based reference model of the microcode rules.
module tb_fsm_trace_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       state_valid = 1'b0;
  logic [3:0] state_in = '0;
  logic       sym_ready = 1'b0;
  logic       sym_valid, sym_ambig, err, overflow;
  logic [1:0] sym_data;
  logic [3:0] err_from, err_to;
  logic [7:0] pass_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_q[$];          // entries encoded as ambig*4 + data
  bit         m_have;
  int         m_prev;
  bit         m_err;
  int         m_from, m_to;
  bit         m_ovf;
  logic [7:0] m_pass;
  int         seq_s;           // last state driven on the random walk

  always #5 clk = ~clk;

  fsm_trace_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .state_valid (state_valid),
    .state_in    (state_in),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_data    (sym_data),
    .sym_ambig   (sym_ambig),
    .err         (err),
    .err_from    (err_from),
    .err_to      (err_to),
    .overflow    (overflow),
    .pass_cnt    (pass_cnt)
  );

  function automatic bit legal_tr(int p, int s);
    case (p)
      0, 1, 2, 6, 7, 8, 9: return s == p + 1;
      3:                   return s >= 4 && s <= 6;
      4, 5:                return s == 7;
      10:                  return s == 11 || s == 12;
      default:             return s == 0;
    endcase
  endfunction

  // Where the sequencer goes from s when fed input symbol in.
  function automatic int seq_next(int s, int in);
    case (s)
      3:       return 4 + ((in > 2) ? 2 : in);
      4, 5:    return 7;
      10:      return 11 + ((in > 0) ? 1 : 0);
      11, 12, 13, 14, 15: return 0;
      default: return s + 1;
    endcase
  endfunction

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_have = 0; m_prev = 0; m_err = 0; m_from = 0; m_to = 0; m_ovf = 0; m_pass = '0;
  endtask

  task automatic check_all(string tag);
    check({tag, ".sym_valid"}, int'(sym_valid), (m_q.size() > 0) ? 1 : 0);
    if (m_q.size() > 0) begin
      check({tag, ".sym_data"}, int'(sym_data), m_q[0] % 4);
      check({tag, ".sym_ambig"}, int'(sym_ambig), m_q[0] / 4);
    end
    check({tag, ".err"}, int'(err), int'(m_err));
    check({tag, ".err_from"}, int'(err_from), m_from);
    check({tag, ".err_to"}, int'(err_to), m_to);
    check({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    check({tag, ".pass_cnt"}, int'(pass_cnt), int'(m_pass));
  endtask

  // One clock: apply inputs, advance the model, compare just after the edge.
  task automatic step(bit v, int s, bit rdy, string tag);
    bit pop, full, push;
    int sym;
    state_valid = v;
    state_in    = 4'(s);
    sym_ready   = rdy;
    @(posedge clk);
    pop  = rdy && (m_q.size() > 0);
    full = (m_q.size() == DEPTH);
    push = 0;
    sym  = 0;
    if (v) begin
      if (m_have) begin
        if (legal_tr(m_prev, s)) begin
          if (m_prev == 3)  begin push = 1; sym = (s - 4) + ((s == 6) ? 4 : 0); end
          if (m_prev == 10) begin push = 1; sym = (s - 11) + ((s == 12) ? 4 : 0); end
          if (s == 0) m_pass = m_pass + 8'd1;
        end else begin
          if (!m_err) begin m_from = m_prev; m_to = s; end
          m_err = 1;
        end
      end
      m_prev = s;
      m_have = 1;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1;
      else m_q.push_back(sym);
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(bit v, int s);
    rst = 1'b1;
    state_valid = v;
    state_in = 4'(s);
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    check("rst.sym_valid", int'(sym_valid), 0);
    check("rst.sym_data", int'(sym_data), 0);
    check("rst.sym_ambig", int'(sym_ambig), 0);
    check_all("rst");
  endtask

  // States 1..10 plus both dispatch targets and the return to 0.
  task automatic loop_tail(int in1, int in2, bit rdy, string tag);
    int s = 0;
    for (int k = 0; k < 11; k++) begin
      s = (k == 0) ? 1 : seq_next(s, (s == 3) ? in1 : in2);
      step(1, s, rdy, tag);
      if (s == 0) break;
    end
  endtask

  initial begin
    model_reset();
    seq_s = 0;

    // Basic loop with inputs 1 and 0.
    do_reset(0, 0);
    step(1, 0, 1, "first");
    loop_tail(1, 0, 1, "loop_a");
    step(0, 0, 1, "drain_a");
    check("loop_a.pass", int'(pass_cnt), 1);
    check("loop_a.err", int'(err), 0);

    // Ambiguous dispatch targets, consumer stalled so both symbols stay queued.
    do_reset(0, 0);
    step(1, 0, 0, "first_b");
    loop_tail(3, 2, 0, "loop_b");
    check("loop_b.head_data", int'(sym_data), 2);
    check("loop_b.head_ambig", int'(sym_ambig), 1);
    step(0, 0, 1, "pop_b");
    check("loop_b.second_data", int'(sym_data), 1);
    check("loop_b.second_ambig", int'(sym_ambig), 1);
    step(0, 0, 1, "pop_b2");

    // First illegal transition is held; later ones do not overwrite it.
    do_reset(0, 0);
    step(1, 0, 1, "err0");
    step(1, 1, 1, "err1");
    step(1, 3, 1, "err2");
    step(1, 4, 1, "err3");
    step(1, 9, 1, "err4");
    check("err.flag", int'(err), 1);
    check("err.from", int'(err_from), 1);
    check("err.to", int'(err_to), 3);
    check("err.no_sym", int'(sym_valid), 0);
    step(1, 10, 1, "err5");
    step(1, 11, 1, "err6");
    step(0, 0, 0, "err7");
    check("err.resync_sym", int'(sym_valid), 1);

    // Overflow: 5 loops with the consumer stalled, then drain in order.
    do_reset(0, 0);
    step(1, 0, 0, "ovf0");
    for (int l = 0; l < 5; l++) loop_tail(l % 4, (l + 1) % 4, 0, "ovf_loop");
    check("ovf.flag", int'(overflow), 1);
    for (int k = 0; k < DEPTH + 2; k++) step(0, 0, 1, "ovf_drain");
    check("ovf.empty", int'(sym_valid), 0);

    // Pass counter wrap after 256 loops.
    do_reset(0, 0);
    step(1, 0, 1, "wrap0");
    for (int l = 0; l < 256; l++) loop_tail(l % 4, (l / 4) % 4, 1, "wrap");
    check("wrap.pass", int'(pass_cnt), 0);

    // Reset mid-loop with a valid sample present; the following sample is unchecked.
    step(1, 1, 1, "mid0");
    step(1, 2, 1, "mid1");
    do_reset(1, 3);
    step(1, 9, 1, "mid_first");
    check("mid.no_err", int'(err), 0);
    step(1, 10, 1, "mid_next");

    // Random walk with occasional glitches, idle cycles and random backpressure.
    do_reset(0, 0);
    seq_s = 0;
    for (int n = 0; n < 3000; n++) begin
      bit v;
      int s;
      v = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) s = $urandom_range(0, 15);
      else s = seq_next(seq_s, $urandom_range(0, 3));
      if (v) seq_s = s;
      step(v, s, $urandom_range(0, 2) != 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
